// File: rtl/driver_display_saida_if.sv
// Bus between the SAP-1 output register and the display driver.
// entrada   : registered 8-bit value to display (upstream -> driver)
// bcd       : last converted value {hundreds, tens, units}
// ocupado   : high while a conversion is running
// anodos    : active-low one-hot digit enables {hundreds, tens, units}
// segmentos : active-low {g,f,e,d,c,b,a} for the enabled digit
interface driver_display_saida_if;
    localparam int unsigned VAL_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned DIG_N = 3;
    localparam int unsigned SEG_W = 7;

    logic [VAL_W-1:0] entrada;
    logic [BCD_W-1:0] bcd;
    logic             ocupado;
    logic [DIG_N-1:0] anodos;
    logic [SEG_W-1:0] segmentos;

    // Upstream side: drives the value, observes the display.
    modport master (
        output entrada,
        input  bcd,
        input  ocupado,
        input  anodos,
        input  segmentos
    );

    // Display driver side.
    modport slave (
        input  entrada,
        output bcd,
        output ocupado,
        output anodos,
        output segmentos
    );
endinterface

// File: rtl/driver_display_saida.sv
// Display driver for the SAP-1 output register: converts the 8-bit value to
// three BCD digits with a sequential double-dabble (one bit per clock) and
// time-multiplexes them onto three 7-segment digits with leading-zero blanking.
// Ports:
//   CLK   : system clock, rising edge
//   CLR_n : asynchronous active-low reset
//   bus   : driver_display_saida_if.slave (entrada in; bcd, ocupado,
//           anodos, segmentos out)
// SCAN_DIV: cycles each digit stays enabled (>= 2).
module driver_display_saida #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic                    CLK,
    input logic                    CLR_n,
    driver_display_saida_if.slave  bus
);
    localparam int unsigned VAL_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned DIG_W = 2;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

    estado_t            state_q, state_n;
    logic [VAL_W-1:0]   valor_ant_q, valor_ant_n;
    logic [VAL_W-1:0]   shift_q, shift_n;
    logic [BCD_W-1:0]   scratch_q, scratch_n;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [BCD_W-1:0]   bcd_q, bcd_n;
    logic               ocupado_q, ocupado_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic [DIG_W-1:0]   dig_q, dig_n;
    logic [2:0]         anodos;
    logic [SEG_W-1:0]   segmentos;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 when doubled.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q     <= OCIOSO;
            valor_ant_q <= '0;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            ocupado_q   <= 1'b0;
            div_q       <= '0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_n;
            valor_ant_q <= valor_ant_n;
            shift_q     <= shift_n;
            scratch_q   <= scratch_n;
            cnt_q       <= cnt_n;
            bcd_q       <= bcd_n;
            ocupado_q   <= ocupado_n;
            div_q       <= div_n;
            dig_q       <= dig_n;
        end
    end

    // Converter next state: capture on change, then eight add-3/shift steps.
    always_comb begin
        state_n     = state_q;
        valor_ant_n = valor_ant_q;
        shift_n     = shift_q;
        scratch_n   = scratch_q;
        cnt_n       = cnt_q;
        bcd_n       = bcd_q;
        ocupado_n   = ocupado_q;
        adj         = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

        case (state_q)
            OCIOSO: begin
                if (bus.entrada != valor_ant_q) begin
                    shift_n     = bus.entrada;
                    scratch_n   = '0;
                    valor_ant_n = bus.entrada;
                    cnt_n       = '0;
                    ocupado_n   = 1'b1;
                    state_n     = CONVERTE;
                end
            end
            CONVERTE: begin
                // Shift the MSB of the binary operand into the corrected BCD scratch.
                scratch_n = {adj[BCD_W-2:0], shift_q[VAL_W-1]};
                shift_n   = {shift_q[VAL_W-2:0], 1'b0};
                cnt_n     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bcd_n     = scratch_n;
                    ocupado_n = 1'b0;
                    state_n   = OCIOSO;
                end
            end
            default: begin
                state_n = OCIOSO;
            end
        endcase
    end

    // Free-running scan divider and digit index, independent of the converter.
    always_comb begin
        div_n = div_q + DIV_W'(1);
        dig_n = dig_q;
        if (div_q == DIV_LAST) begin
            div_n = '0;
            dig_n = (dig_q == DIG_W'(2)) ? '0 : dig_q + DIG_W'(1);
        end
    end

    // Digit decode with leading-zero blanking; units is always shown.
    always_comb begin
        anodos    = 3'b111;
        segmentos = SEG_BLANK;
        case (dig_q)
            2'd0: begin
                anodos    = 3'b110;
                segmentos = seg7(bcd_q[3:0]);
            end
            2'd1: begin
                anodos    = 3'b101;
                segmentos = (bcd_q[11:4] == 8'h00) ? SEG_BLANK : seg7(bcd_q[7:4]);
            end
            2'd2: begin
                anodos    = 3'b011;
                segmentos = (bcd_q[11:8] == 4'h0) ? SEG_BLANK : seg7(bcd_q[11:8]);
            end
            default: begin
                anodos    = 3'b111;
                segmentos = SEG_BLANK;
            end
        endcase
    end

    assign bus.bcd       = bcd_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.anodos    = anodos;
    assign bus.segmentos = segmentos;
endmodule

// File: tb/tb_driver_display_saida.sv
// Directed bench for driver_display_saida: one instance with SCAN_DIV=4 for
// conversion/display checks and one with SCAN_DIV=2 for the scan sequence.
module tb_driver_display_saida;
    logic clk;
    logic clr_n;
    int   checks;
    int   errors;

    driver_display_saida_if bus4();
    driver_display_saida_if bus2();

    driver_display_saida #(.SCAN_DIV(4)) dut4 (
        .CLK   (clk),
        .CLR_n (clr_n),
        .bus   (bus4)
    );

    driver_display_saida #(.SCAN_DIV(2)) dut2 (
        .CLK   (clk),
        .CLR_n (clr_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Align to the first units cycle, then verify three 4-cycle digit slots.
    task automatic scan_check(input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh);
        int n;
        logic [2:0] ea;
        logic [6:0] es;
        n = 0;
        while (bus4.anodos != 3'b011 && n < 20) begin tick(); n++; end
        while (bus4.anodos == 3'b011 && n < 40) begin tick(); n++; end
        check("scan_sync", 32'(n < 40), 32'd1);
        for (int k = 0; k < 12; k++) begin
            case (k / 4)
                0:       begin ea = 3'b110; es = su; end
                1:       begin ea = 3'b101; es = st; end
                default: begin ea = 3'b011; es = sh; end
            endcase
            check("scan_anodos", 32'(bus4.anodos), 32'(ea));
            check("scan_seg", 32'(bus4.segmentos), 32'(es));
            tick();
        end
    endtask

    // Load on the next edge, then wait the remaining eight conversion steps.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd, input string tag);
        int hi;
        bus4.entrada = v;
        tick();
        check({tag, "_busy_e1"}, 32'(bus4.ocupado), 32'd1);
        hi = 0;
        while (bus4.ocupado && hi < 20) begin
            check({tag, "_bcd_old"}, 32'(bus4.bcd == exp_bcd && exp_bcd != 12'h000 ? 1 : 0), 32'd0);
            hi++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(hi), 32'd8);
        check({tag, "_bcd"}, 32'(bus4.bcd), 32'(exp_bcd));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_n = 1'b0;
        bus4.entrada = 8'h00;
        bus2.entrada = 8'h00;

        // Reset values
        ticks(2);
        check("rst_bcd", 32'(bus4.bcd), 32'h000);
        check("rst_ocupado", 32'(bus4.ocupado), 32'd0);
        check("rst_anodos", 32'(bus4.anodos), 32'(3'b110));
        check("rst_seg", 32'(bus4.segmentos), 32'(S0));
        clr_n = 1'b1;

        // No change on entrada: nothing starts
        tick();
        check("idle_ocupado", 32'(bus4.ocupado), 32'd0);

        // Full scale
        convert(8'hFF, 12'h255, "ff");
        scan_check(S5, S5, S2);

        // Leading-zero blanking
        convert(8'h07, 12'h007, "x07");
        scan_check(S7, SB, SB);
        convert(8'h64, 12'h100, "x64");
        scan_check(S0, S0, S1);

        // Input change mid-conversion, then back-to-back reload at E10
        bus4.entrada = 8'hF0;
        tick();
        check("mid_busy_e1", 32'(bus4.ocupado), 32'd1);
        ticks(3);
        bus4.entrada = 8'h0F;
        ticks(4);
        check("mid_busy_e8", 32'(bus4.ocupado), 32'd1);
        check("mid_bcd_e8", 32'(bus4.bcd), 32'h100);
        tick();
        check("mid_bcd_e9", 32'(bus4.bcd), 32'h240);
        check("mid_idle_e9", 32'(bus4.ocupado), 32'd0);
        tick();
        check("mid_busy_e10", 32'(bus4.ocupado), 32'd1);
        ticks(7);
        check("mid_bcd_e17", 32'(bus4.bcd), 32'h240);
        tick();
        check("mid_bcd_e18", 32'(bus4.bcd), 32'h015);
        check("mid_idle_e18", 32'(bus4.ocupado), 32'd0);

        // Reset mid-conversion, asserted between edges
        bus4.entrada = 8'h80;
        tick();
        check("rmid_busy", 32'(bus4.ocupado), 32'd1);
        ticks(3);
        #2;
        clr_n = 1'b0;
        #1;
        check("rmid_bcd", 32'(bus4.bcd), 32'h000);
        check("rmid_ocupado", 32'(bus4.ocupado), 32'd0);
        check("rmid_anodos", 32'(bus4.anodos), 32'(3'b110));
        check("rmid_seg", 32'(bus4.segmentos), 32'(S0));
        tick();
        clr_n = 1'b1;
        check("rmid_hold_bcd", 32'(bus4.bcd), 32'h000);
        tick();
        check("rmid_restart", 32'(bus4.ocupado), 32'd1);
        ticks(7);
        check("rmid_bcd_e8", 32'(bus4.bcd), 32'h000);
        tick();
        check("rmid_bcd_e9", 32'(bus4.bcd), 32'h128);

        // Glitch that returns to the stored value before the edge
        bus4.entrada = 8'h81;
        #2;
        bus4.entrada = 8'h80;
        tick();
        check("glitch_idle", 32'(bus4.ocupado), 32'd0);
        check("glitch_bcd", 32'(bus4.bcd), 32'h128);

        // Scan wrap with SCAN_DIV=2 from a fresh reset
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [2:0] ea;
            case ((k / 2) % 3)
                0:       ea = 3'b110;
                1:       ea = 3'b101;
                default: ea = 3'b011;
            endcase
            check("wrap_anodos", 32'(bus2.anodos), 32'(ea));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
